alu_seq_param: RTL
==================

// Module: alu_seq_param
//
// PURPOSE
//   WIDTH-parametrised ALU that succeeds the fixed 16-bit ALU.
//   Registered single-cycle logic and arithmetic ops, plus an iterative shift-add
//   multiply that takes WIDTH cycles.
//   Uses a valid/ready handshake on both sides. Sits between the register-read
//   stage and writeback of the datapath.
//   Flags (cout, overflow, zero) are carried with the result.
//
// PARAMETERS
//   WIDTH      16   operand/result width; multiple of 4, >= 8
//   SLICE_W     4   carry-lookahead slice width; WIDTH % SLICE_W == 0
//
// PORTS
//   clk        in   1        single clock, rising edge
//   reset      in   1        synchronous, active-high
//   in_valid   in   1        operands/op presented
//   in_ready   out  1        ALU can accept; transfer when in_valid & in_ready
//   a          in   WIDTH    operand A (two's complement for SLT/overflow)
//   b          in   WIDTH    operand B
//   op         in   3        000 AND, 001 OR, 010 ADD, 011 MUL, 100 NOR, 110 SUB, 111 SLT
//   out_valid  out  1        result/flags valid
//   out_ready  in   1        consumer accepts; transfer when out_valid & out_ready
//   result     out  WIDTH    result (MUL: low half of product)
//   result_hi  out  WIDTH    MUL high half of product; 0 for all other ops
//   cout       out  1        carry out of MSB (ADD/SUB/SLT); 0 otherwise
//   overflow   out  1        signed overflow (ADD/SUB); 0 otherwise
//   zero       out  1        result == 0 (MUL: {result_hi,result} == 0)
//
// BEHAVIOUR
//   - Reset: state IDLE; out_valid=0, in_ready=1, result=0, result_hi=0,
//     cout=0, overflow=0, zero=0. A reset in any state (including mid-MUL)
//     aborts and discards the operation; no output is produced for it.
//   - FSM states: IDLE, MUL, DONE.
//       * IDLE, accept, op != MUL -> DONE. Outputs are registered at the
//         accepting edge, so latency is 1 cycle.
//       * IDLE, accept, op == MUL -> MUL. Counter is loaded with WIDTH.
//       * MUL: one shift-add step per cycle. After WIDTH steps -> DONE.
//         Latency is WIDTH+1 cycles from accept to out_valid.
//       * DONE: out_valid=1 and outputs are held stable.
//         On out_ready=1 -> IDLE.
//   - in_ready=1 only in IDLE. There is no accept in DONE, even when
//     out_ready=1 (no back-to-back overlap). Throughput is at most 1 op per
//     2 cycles.
//   - Inputs a, b and op are captured on accept. Later changes to them have
//     no effect on an op in flight.
//   - SUB: a + ~b + 1. cout=1 means no borrow.
//   - overflow = carry into MSB XOR carry out of MSB.
//   - SLT: result = {WIDTH-1 zeros, sign(a-b) XOR overflow(a-b)}. Signed compare.
//   - MUL: unsigned product. cout=0, overflow=0.
//   - Undefined ops (101) behave as AND, with all flags except zero forced to 0.
//   - Adder: WIDTH/SLICE_W CLA slices. Each slice exports G/P, which feed a
//     second-level lookahead. The full ADD/SUB path must close timing in one cycle.
//
// STRUCTURE
//   - alu_pkg: op encodings (OP_AND..OP_SLT), FSM state enum, DEFAULT_WIDTH.
//   - Sub-module alu_cla_slice: SLICE_W-bit carry-lookahead adder with
//     a, b, cin inputs and sum, G, P outputs. Instantiated WIDTH/SLICE_W
//     times by generate.
//   - The multiply datapath (accumulator, multiplier shift register, counter of
//     $clog2(WIDTH)+1 bits) is inline in the top level.
//
// TESTING (WIDTH=16)
//   1. ADD a=16'h7FFF b=16'h0001 -> next cycle out_valid=1, result=16'h8000,
//      overflow=1, cout=0, zero=0.
//   2. SUB a=16'h0009 b=16'h0009 -> result=16'h0000, zero=1, cout=1, overflow=0.
//   3. SLT a=16'h8000 b=16'h0001 -> result=16'h0001. Swapped operands -> 16'h0000.
//   4. MUL a=16'h00FF b=16'h0101 -> in_ready=0 for 17 cycles; then out_valid=1,
//      result=16'hFFFF, result_hi=16'h0000. Also MUL 16'hFFFF*16'hFFFF ->
//      hi=16'hFFFE, lo=16'h0001.
//   5. Backpressure: out_ready=0 for 3 cycles after out_valid -> outputs stable,
//      in_ready=0, in_valid ignored. out_ready=1 -> IDLE the next cycle.
//   6. reset=1 at cycle 5 of a MUL -> next cycle out_valid=0, in_ready=1,
//      result=0. A following ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op encodings, FSM state codes and default width for the sequential ALU.
package alu_pkg;
  localparam int DEFAULT_WIDTH = 16;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_NOR = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/alu_cla_slice.sv
// SLICE_W-bit carry-lookahead slice; exports group generate/propagate so the
// top level can resolve inter-slice carries without rippling through sums.
module alu_cla_slice #(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               g,
  output logic               p
);
  logic [SLICE_W-1:0] gi, pi, c;

  assign gi = a & b;
  assign pi = a ^ b;

  // Group G/P deliberately independent of cin: the second-level lookahead relies on it.
  always_comb begin
    c    = '0;
    c[0] = cin;
    g    = 1'b0;
    p    = 1'b1;
    for (int i = 0; i < SLICE_W; i++) begin
      if (i < SLICE_W - 1) c[i+1] = gi[i] | (pi[i] & c[i]);
      g = gi[i] | (pi[i] & g);
      p = p & pi[i];
    end
  end

  assign sum = pi ^ c;
endmodule

// File: rtl/alu_seq_param.sv
// WIDTH-parametrised ALU: registered single-cycle logic/arith ops and an
// iterative shift-add multiply, with valid/ready on both sides.
module alu_seq_param
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SLICE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int NS = WIDTH / SLICE_W;
  localparam int CW = $clog2(WIDTH) + 1;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, mq, mcand;

  logic             sub_mode;
  logic [WIDTH-1:0] bx, sum;
  logic [NS-1:0]    sg, sp;
  logic [NS:0]      sc;
  logic             add_cout, add_ovf;

  assign in_ready = (state == S_IDLE);
  assign sub_mode = (op == OP_SUB) || (op == OP_SLT);
  assign bx       = sub_mode ? ~b : b;

  for (genvar k = 0; k < NS; k++) begin : g_slice
    alu_cla_slice #(.SLICE_W(SLICE_W)) u_slice (
      .a   (a[k*SLICE_W +: SLICE_W]),
      .b   (bx[k*SLICE_W +: SLICE_W]),
      .cin (sc[k]),
      .sum (sum[k*SLICE_W +: SLICE_W]),
      .g   (sg[k]),
      .p   (sp[k])
    );
  end

  always_comb begin
    sc    = '0;
    sc[0] = sub_mode;
    for (int k = 0; k < NS; k++) sc[k+1] = sg[k] | (sp[k] & sc[k]);
  end

  // Carry into the MSB is recovered from the MSB sum bit rather than exported.
  assign add_cout = sc[NS];
  assign add_ovf  = add_cout ^ (sum[WIDTH-1] ^ a[WIDTH-1] ^ bx[WIDTH-1]);

  logic [WIDTH-1:0] res_n;
  logic             cout_n, ovf_n;

  always_comb begin
    res_n  = a & b;
    cout_n = 1'b0;
    ovf_n  = 1'b0;
    case (op)
      OP_OR:  res_n = a | b;
      OP_NOR: res_n = ~(a | b);
      OP_ADD, OP_SUB: begin
        res_n  = sum;
        cout_n = add_cout;
        ovf_n  = add_ovf;
      end
      OP_SLT: begin
        res_n  = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
        cout_n = add_cout;
      end
      default: res_n = a & b;
    endcase
  end

  // {acc,mq} shifts right each step; mq's low bit selects whether to add mcand.
  logic [WIDTH:0]   mstep;
  logic [WIDTH-1:0] acc_n, mq_n;

  assign mstep = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
  assign acc_n = mstep[WIDTH:1];
  assign mq_n  = {mstep[0], mq[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      mq        <= '0;
      mcand     <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          if (op == OP_MUL) begin
            acc   <= '0;
            mq    <= b;
            mcand <= a;
            cnt   <= CW'(WIDTH);
            state <= S_MUL;
          end else begin
            result    <= res_n;
            result_hi <= '0;
            cout      <= cout_n;
            overflow  <= ovf_n;
            zero      <= (res_n == '0);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_MUL: begin
          acc <= acc_n;
          mq  <= mq_n;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result    <= mq_n;
            result_hi <= acc_n;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            zero      <= ({acc_n, mq_n} == '0);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
